arith_testbench_pipe: RTL and testbench
=======================================

# arith_testbench_pipe

Self-checking stimulus/check harness for a pipelined two-operand arithmetic DUT: generates pseudo-random operands, aligns them against a DUT of configurable latency, compares the DUT result with a built-in reference model and counts samples and mismatches. Next-generation harness: single clock, selectable operation, fill/run sequencing, clear, saturating counters and optional first-error capture. Sits between the system host and the DUT conduit.

## Interface
- WIDTH, 32: operand/result width, 8..32.
- CTR_WIDTH, 32: counter width, 4..32.
- LATENCY, 2: DUT pipeline depth in cycles, 1..16.
- MODE, 0: reference op; 0 = a+b, 1 = a-b, 2 = a*b low WIDTH bits (all mod 2^WIDTH).
- SEED_A, 32'hCAFEF00D / SEED_B, 32'hFEEDC0DE: LFSR seeds.

- clk  in  1  sole clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- i_enable  in  1  run request.
- i_freeze  in  1  hold counters.
- i_clear  in  1  synchronous clear of counters and capture.
- o_drive_a  out  WIDTH  operand A to DUT.
- o_drive_b  out  WIDTH  operand B to DUT.
- i_dut_out  in  WIDTH  DUT result.
- o_state  out  2  00 IDLE, 01 FILL, 10 RUN.
- o_data_ctr  out  CTR_WIDTH  compared samples.
- o_event_ctr  out  CTR_WIDTH  mismatches.
- o_err_valid  out  1  first mismatch captured.
- o_err_a, o_err_b, o_err_got  out  WIDTH  captured operands/result.

## Operation
- Two 32-bit Galois LFSRs, taps 32'h80200003, shift right; zero seed replaced by 32'h1. Drives = LFSR[WIDTH-1:0], registered.
- LFSRs advance only in FILL/RUN; held in IDLE.
- Delay line: LATENCY-deep shift register of {a,b}, shifts every cycle in every state (tracks held drives while idle).
- FSM: IDLE -> FILL when i_enable=1; FILL counts LATENCY cycles, then -> RUN; FILL/RUN -> IDLE when i_enable=0 (any cycle). Re-enable always re-enters FILL.
- RUN: each cycle compare i_dut_out with model(delayed a, delayed b); data_ctr +1; event_ctr +1 on mismatch.
- Counters saturate at all-ones, never wrap.
- i_freeze=1: counters and capture hold; comparison continues, LFSRs unaffected.
- i_clear=1: counters, o_err_* zeroed; priority over increment and freeze; FSM unaffected.
- Reset (any time): state IDLE, LFSRs to seeds, delay line, counters, all outputs 0 except drives = seeds[WIDTH-1:0] on first edge after release.

## Timing
- Drive change at edge t is checked against i_dut_out sampled at edge t+LATENCY.
- Comparison registered: counters reflect the sample one cycle after it is taken.
- i_enable sampled high at edge 0: FILL edges 1..LATENCY, first compare at edge LATENCY+1; after N enabled edges, data_ctr = N - LATENCY (N > LATENCY), visible next cycle.
- i_enable low: compare stops the same edge; last increment lands next cycle.
- o_state registered, updates on the transition edge.

## Configuration
- ARITH_TB_ERR_CAPTURE_EN defined: first mismatch in RUN (while not frozen and o_err_valid=0) loads o_err_a/b/got and sets o_err_valid; held until i_clear or reset.
- Undefined: capture logic absent; o_err_valid and o_err_* tied to 0.

## Test plan
- WIDTH=32, MODE=0, LATENCY=2, ideal adder DUT, enable 100 edges -> data_ctr=98, event_ctr=0, o_state 00->01->10.
- Same, DUT result bit0 flipped on one sample -> event_ctr=1; with macro o_err_valid=1, o_err_got = a+b ^ 1.
- MODE=2, LATENCY=5, WIDTH=16, DUT delay 4 -> every sample mismatches except coincidences; event_ctr ≈ data_ctr, nonzero.
- CTR_WIDTH=4, faulty DUT, 40 enabled edges -> both counters stick at 4'hF; i_clear for 1 cycle -> 0, counting resumes.
- i_freeze high mid-run for 10 cycles -> counters unchanged over window, resume +1/cycle after.
- Reset low mid-RUN -> immediately o_state=00, counters 0, drives = 32'hCAFEF00D/32'hFEEDC0DE after release.

Source files
------------

// File: rtl/arith_testbench_pipe_if.sv
// Conduit between the arithmetic test harness and the DUT under test.
// The harness drives the operands and receives the DUT result.
interface arith_testbench_pipe_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] drive_a;
  logic [WIDTH-1:0] drive_b;
  logic [WIDTH-1:0] dut_out;

  modport master (output drive_a, output drive_b, input dut_out);
  modport slave  (input drive_a, input drive_b, output dut_out);
endinterface

// File: rtl/arith_testbench_pipe.sv
// LFSR stimulus / reference-model checker for a pipelined two-operand arithmetic DUT.
// Optional first-mismatch capture is built when ARITH_TB_ERR_CAPTURE_EN is defined.
module arith_testbench_pipe #(
  parameter int          WIDTH     = 32,
  parameter int          CTR_WIDTH = 32,
  parameter int          LATENCY   = 2,
  parameter int          MODE      = 0,
  parameter logic [31:0] SEED_A    = 32'hCAFEF00D,
  parameter logic [31:0] SEED_B    = 32'hFEEDC0DE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic                   i_freeze,
  input  logic                   i_clear,
  arith_testbench_pipe_if.master dut,
  output logic [1:0]             o_state,
  output logic [CTR_WIDTH-1:0]   o_data_ctr,
  output logic [CTR_WIDTH-1:0]   o_event_ctr,
  output logic                   o_err_valid,
  output logic [WIDTH-1:0]       o_err_a,
  output logic [WIDTH-1:0]       o_err_b,
  output logic [WIDTH-1:0]       o_err_got
);

  localparam logic [31:0] TAPS      = 32'h80200003;
  localparam logic [31:0] INIT_A    = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] INIT_B    = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
  localparam logic [4:0]  FILL_LAST = 5'(LATENCY - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  state_t state_reg, state_next;
  logic [4:0] fill_reg, fill_next;

  logic [31:0]        lfsr_a_reg, lfsr_b_reg;
  logic [WIDTH-1:0]   drive_a_reg, drive_b_reg;
  logic [2*WIDTH-1:0] dly_reg [LATENCY];

  logic               sample_valid_reg, sample_miss_reg;
  logic [CTR_WIDTH-1:0] data_ctr_reg, event_ctr_reg;

  logic [WIDTH-1:0]   dly_a, dly_b, expected;
  logic               run_cmp;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (MODE)
      1:       return a - b;
      2:       return a * b;
      default: return a + b;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      fill_reg  <= '0;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
    end
  end

  // Any drop of i_enable returns to IDLE; re-enabling always refills the pipe.
  always_comb begin
    state_next = state_reg;
    fill_next  = fill_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_enable) begin
          state_next = ST_FILL;
          fill_next  = '0;
        end
      end
      ST_FILL: begin
        if (!i_enable)
          state_next = ST_IDLE;
        else if (fill_reg == FILL_LAST)
          state_next = ST_RUN;
        else
          fill_next = fill_reg + 5'd1;
      end
      ST_RUN: begin
        if (!i_enable)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_a_reg  <= INIT_A;
      lfsr_b_reg  <= INIT_B;
      drive_a_reg <= '0;
      drive_b_reg <= '0;
    end else begin
      drive_a_reg <= lfsr_a_reg[WIDTH-1:0];
      drive_b_reg <= lfsr_b_reg[WIDTH-1:0];
      if (state_reg != ST_IDLE) begin
        lfsr_a_reg <= lfsr_step(lfsr_a_reg);
        lfsr_b_reg <= lfsr_step(lfsr_b_reg);
      end
    end
  end

  // Stage 0 loads in parallel with the drive registers, so stage k holds the
  // operands driven k+1 edges ago.
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dly
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          dly_reg[gi] <= '0;
        else if (gi == 0)
          dly_reg[gi] <= {lfsr_a_reg[WIDTH-1:0], lfsr_b_reg[WIDTH-1:0]};
        else
          dly_reg[gi] <= dly_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  assign dly_a    = dly_reg[LATENCY-1][2*WIDTH-1:WIDTH];
  assign dly_b    = dly_reg[LATENCY-1][WIDTH-1:0];
  assign expected = model(dly_a, dly_b);
  assign run_cmp  = (state_reg == ST_RUN) && i_enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_valid_reg <= 1'b0;
      sample_miss_reg  <= 1'b0;
    end else begin
      sample_valid_reg <= run_cmp;
      sample_miss_reg  <= run_cmp && (dut.dut_out != expected);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_ctr_reg  <= '0;
      event_ctr_reg <= '0;
    end else if (i_clear) begin
      data_ctr_reg  <= '0;
      event_ctr_reg <= '0;
    end else if (!i_freeze && sample_valid_reg) begin
      if (data_ctr_reg != CTR_MAX)
        data_ctr_reg <= data_ctr_reg + 1'b1;
      if (sample_miss_reg && event_ctr_reg != CTR_MAX)
        event_ctr_reg <= event_ctr_reg + 1'b1;
    end
  end

`ifdef ARITH_TB_ERR_CAPTURE_EN
  logic [WIDTH-1:0] sample_a_reg, sample_b_reg, sample_got_reg;
  logic             err_valid_reg;
  logic [WIDTH-1:0] err_a_reg, err_b_reg, err_got_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_a_reg   <= '0;
      sample_b_reg   <= '0;
      sample_got_reg <= '0;
    end else begin
      sample_a_reg   <= dly_a;
      sample_b_reg   <= dly_b;
      sample_got_reg <= dut.dut_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_valid_reg <= 1'b0;
      err_a_reg     <= '0;
      err_b_reg     <= '0;
      err_got_reg   <= '0;
    end else if (i_clear) begin
      err_valid_reg <= 1'b0;
      err_a_reg     <= '0;
      err_b_reg     <= '0;
      err_got_reg   <= '0;
    end else if (!i_freeze && sample_valid_reg && sample_miss_reg && !err_valid_reg) begin
      err_valid_reg <= 1'b1;
      err_a_reg     <= sample_a_reg;
      err_b_reg     <= sample_b_reg;
      err_got_reg   <= sample_got_reg;
    end
  end

  assign o_err_valid = err_valid_reg;
  assign o_err_a     = err_a_reg;
  assign o_err_b     = err_b_reg;
  assign o_err_got   = err_got_reg;
`else
  assign o_err_valid = 1'b0;
  assign o_err_a     = '0;
  assign o_err_b     = '0;
  assign o_err_got   = '0;
`endif

  assign dut.drive_a = drive_a_reg;
  assign dut.drive_b = drive_b_reg;
  assign o_state     = state_reg;
  assign o_data_ctr  = data_ctr_reg;
  assign o_event_ctr = event_ctr_reg;

endmodule

// File: tb/tb_arith_testbench_pipe.sv
// Directed bench: an ideal adder (with one-shot fault) on a 32-bit harness and a
// mismatched-latency multiplier on a 16-bit / 4-bit-counter harness.
module tb_arith_testbench_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- harness 1: WIDTH 32, LATENCY 2, MODE 0 ----------------
  logic        enable1 = 1'b0, freeze1 = 1'b0, clear1 = 1'b0, flip = 1'b0;
  logic [1:0]  state1;
  logic [31:0] data1, event1, err_a1, err_b1, err_got1;
  logic        err_valid1;
  logic [31:0] a1_q, b1_q;

  arith_testbench_pipe_if #(.WIDTH(32)) bus1 ();

  arith_testbench_pipe #(
    .WIDTH(32), .CTR_WIDTH(32), .LATENCY(2), .MODE(0),
    .SEED_A(32'hCAFEF00D), .SEED_B(32'hFEEDC0DE)
  ) u_h1 (
    .clk(clk), .reset(reset), .i_enable(enable1), .i_freeze(freeze1), .i_clear(clear1),
    .dut(bus1.master), .o_state(state1), .o_data_ctr(data1), .o_event_ctr(event1),
    .o_err_valid(err_valid1), .o_err_a(err_a1), .o_err_b(err_b1), .o_err_got(err_got1)
  );

  // Latency-2 adder: one register after the harness drive register.
  always_ff @(posedge clk) begin
    a1_q <= bus1.drive_a;
    b1_q <= bus1.drive_b;
  end
  assign bus1.dut_out = (a1_q + b1_q) ^ {31'b0, flip};

  // ---------------- harness 2: WIDTH 16, LATENCY 5, MODE 2, CTR 4 ----------------
  logic        enable2 = 1'b0, clear2 = 1'b0;
  logic [1:0]  state2;
  logic [3:0]  data2, event2;
  logic [15:0] err_a2, err_b2, err_got2;
  logic        err_valid2;
  logic [15:0] pa [3];
  logic [15:0] pb [3];
  logic [15:0] prod2;

  arith_testbench_pipe_if #(.WIDTH(16)) bus2 ();

  arith_testbench_pipe #(
    .WIDTH(16), .CTR_WIDTH(4), .LATENCY(5), .MODE(2)
  ) u_h2 (
    .clk(clk), .reset(reset), .i_enable(enable2), .i_freeze(1'b0), .i_clear(clear2),
    .dut(bus2.master), .o_state(state2), .o_data_ctr(data2), .o_event_ctr(event2),
    .o_err_valid(err_valid2), .o_err_a(err_a2), .o_err_b(err_b2), .o_err_got(err_got2)
  );

  // Multiplier with latency 4 against a harness expecting 5: samples misalign.
  always_ff @(posedge clk) begin
    pa[0] <= bus2.drive_a;  pb[0] <= bus2.drive_b;
    pa[1] <= pa[0];         pb[1] <= pb[0];
    pa[2] <= pa[1];         pb[2] <= pb[1];
  end
  assign prod2 = pa[2] * pb[2];
  assign bus2.dut_out = prod2;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, got, exp);
  endtask

  logic [31:0] fa, fb, v, w;

  initial begin
    // Reset asserted: everything zero.
    #1;
    check("rst_state", 64'(state1), 64'd0);
    check("rst_drive_a", 64'(bus1.drive_a), 64'd0);
    check("rst_data", 64'(data1), 64'd0);
    check("rst_event", 64'(event1), 64'd0);
    step(2);
    reset = 1'b1;
    step(1);
    check("seed_a", 64'(bus1.drive_a), 64'hCAFEF00D);
    check("seed_b", 64'(bus1.drive_b), 64'hFEEDC0DE);

    // Edge 0 samples the request, then 100 active edges with enable high.
    enable1 = 1'b1;
    step(1);
    check("state_fill0", 64'(state1), 64'd1);
    step(1);
    check("state_fill1", 64'(state1), 64'd1);
    step(1);
    check("state_run", 64'(state1), 64'd2);
    check("lfsr_a_step1", 64'(bus1.drive_a), 64'hE55F7805);
    check("lfsr_b_step1", 64'(bus1.drive_b), 64'h7F76E06F);
    step(98);
    enable1 = 1'b0;
    step(1);
    check("state_idle", 64'(state1), 64'd0);
    check("data_ctr_98", 64'(data1), 64'd98);
    check("event_ctr_0", 64'(event1), 64'd0);
    step(3);
    check("data_ctr_hold", 64'(data1), 64'd98);

    // Single bit-0 fault on one sample.
    clear1 = 1'b1;
    step(1);
    clear1 = 1'b0;
    check("clear_data", 64'(data1), 64'd0);
    enable1 = 1'b1;
    step(3);
    step(5);
    flip = 1'b1;
    fa = a1_q;
    fb = b1_q;
    step(1);
    flip = 1'b0;
    step(1);
    check("fault_event", 64'(event1), 64'd1);
    check("fault_data", 64'(data1), 64'd6);
`ifdef ARITH_TB_ERR_CAPTURE_EN
    check("err_valid", 64'(err_valid1), 64'd1);
    check("err_a", 64'(err_a1), 64'(fa));
    check("err_b", 64'(err_b1), 64'(fb));
    check("err_got", 64'(err_got1), 64'((fa + fb) ^ 32'h1));
`else
    check("err_valid", 64'(err_valid1), 64'd0);
    check("err_got", 64'(err_got1), 64'd0);
`endif

    // Freeze window of 10 cycles mid-run.
    freeze1 = 1'b1;
    step(1);
    v = data1;
    step(10);
    check("freeze_data", 64'(data1), 64'(v));
    check("freeze_event", 64'(event1), 64'd1);
    freeze1 = 1'b0;
    step(1);
    w = data1;
    check("unfreeze_inc", 64'(w), 64'(v + 32'd1));
    step(5);
    check("resume_rate", 64'(data1), 64'(w + 32'd5));

    // Asynchronous reset in the middle of RUN.
    reset = 1'b0;
    #2;
    check("mid_rst_state", 64'(state1), 64'd0);
    check("mid_rst_data", 64'(data1), 64'd0);
    check("mid_rst_event", 64'(event1), 64'd0);
    check("mid_rst_drive", 64'(bus1.drive_a), 64'd0);
    check("mid_rst_errv", 64'(err_valid1), 64'd0);
    enable1 = 1'b0;
    reset = 1'b1;
    step(1);
    check("post_rst_a", 64'(bus1.drive_a), 64'hCAFEF00D);
    check("post_rst_b", 64'(bus1.drive_b), 64'hFEEDC0DE);
    check("post_rst_state", 64'(state1), 64'd0);

    // Harness 2: misaligned multiplier saturates 4-bit counters.
    enable2 = 1'b1;
    step(41);
    check("h2_state_run", 64'(state2), 64'd2);
    check("sat_data", 64'(data2), 64'hF);
    check("sat_event", 64'(event2), 64'hF);
    clear2 = 1'b1;
    step(1);
    clear2 = 1'b0;
    check("clr2_data", 64'(data2), 64'd0);
    check("clr2_event", 64'(event2), 64'd0);
    check("clr2_errv", 64'(err_valid2), 64'd0);
    check("clr2_err_a", 64'(err_a2), 64'd0);
    step(3);
    check("clr2_resume", 64'(data2), 64'd3);
    enable2 = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
